// File: rtl/vector_addsub_folded_if.sv
// Operand/result bundle for vector_addsub_folded: A, B, sub and inReady toward the adder.
// Packed results and status flags come back from the adder.
interface vector_addsub_folded_if #(
    parameter int IN_WIDTH = 16,
    parameter int VEC_LEN  = 10
);
    logic                            inReady;
    logic                            sub;
    logic [VEC_LEN*IN_WIDTH-1:0]     A;
    logic [VEC_LEN*IN_WIDTH-1:0]     B;
    logic [VEC_LEN*(IN_WIDTH+1)-1:0] S;
    logic                            outReady;
    logic                            earlyOutReady;
    logic                            busy;
    logic                            dropped;
    logic                            ovf;

    modport master (
        output inReady, sub, A, B,
        input  S, outReady, earlyOutReady, busy, dropped, ovf
    );

    modport slave (
        input  inReady, sub, A, B,
        output S, outReady, earlyOutReady, busy, dropped, ovf
    );
endinterface

// File: rtl/vector_addsub_folded.sv
// Time-folded signed vector add/sub: LANES adders over BEATS=ceil(VEC_LEN/LANES) beats; VADD_SAT_EN adds clamping and ovf.
// Latency: outReady the cycle after the BEATS-th enabled edge following accept; earlyOutReady one cycle before it.
// Backpressure: none; inReady while busy is discarded and recorded on the sticky dropped flag.
module vector_addsub_folded #(
    parameter int IN_WIDTH = 16,
    parameter int VEC_LEN  = 10,
    parameter int LANES    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    vector_addsub_folded_if.slave bus
);
    localparam int EW    = IN_WIDTH + 1;
    localparam int BEATS = (VEC_LEN + LANES - 1) / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS - 1);
    localparam logic [BW-1:0] EARLY_BEAT = BW'((BEATS > 1) ? BEATS - 2 : 0);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                     state_q, state_d;
    logic [BW-1:0]              beat_q, beat_d;
    logic                       accept;
    logic                       last_beat;
    logic                       early_d;
    logic                       out_q;
    logic                       early_q;
    logic                       dropped_q;
    logic                       sub_q;
    logic signed [IN_WIDTH-1:0] opa_q [VEC_LEN];
    logic signed [IN_WIDTH-1:0] opb_q [VEC_LEN];
    logic signed [EW-1:0]       s_q   [VEC_LEN];
    logic signed [IN_WIDTH-1:0] lane_a   [LANES];
    logic signed [IN_WIDTH-1:0] lane_b   [LANES];
    logic signed [EW-1:0]       lane_raw [LANES];
    logic signed [EW-1:0]       lane_res [LANES];
`ifdef VADD_SAT_EN
    logic                       lane_clamp [LANES];
    logic                       ovf_q;
`endif

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        accept    = 1'b0;
        last_beat = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.inReady) begin
                    accept  = 1'b1;
                    state_d = RUN;
                    beat_d  = '0;
                end
            end
            RUN: begin
                if (beat_q == LAST_BEAT) begin
                    last_beat = 1'b1;
                    state_d   = IDLE;
                    beat_d    = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A single-beat fold has no earlier beat to flag, so the accept edge carries it.
        early_d = (BEATS == 1) ? accept : (state_q == RUN && beat_q == EARLY_BEAT);
    end

    // Lane l serves elements l, l+LANES, l+2*LANES, ...; the beat counter picks which one.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_a[l] = '0;
            lane_b[l] = '0;
            for (int i = l; i < VEC_LEN; i += LANES) begin
                if (beat_q == BW'(i / LANES)) begin
                    lane_a[l] = opa_q[i];
                    lane_b[l] = opb_q[i];
                end
            end
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_raw[l] = sub_q ? ({lane_a[l][IN_WIDTH-1], lane_a[l]} - {lane_b[l][IN_WIDTH-1], lane_b[l]})
                                : ({lane_a[l][IN_WIDTH-1], lane_a[l]} + {lane_b[l][IN_WIDTH-1], lane_b[l]});
`ifdef VADD_SAT_EN
            lane_clamp[l] = lane_raw[l][EW-1] != lane_raw[l][EW-2];
            lane_res[l]   = lane_clamp[l] ? {{2{lane_raw[l][EW-1]}}, {(IN_WIDTH-1){~lane_raw[l][EW-1]}}}
                                          : lane_raw[l];
`else
            lane_res[l]   = lane_raw[l];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            sub_q     <= 1'b0;
            out_q     <= 1'b0;
            early_q   <= 1'b0;
            dropped_q <= 1'b0;
`ifdef VADD_SAT_EN
            ovf_q     <= 1'b0;
`endif
            for (int i = 0; i < VEC_LEN; i++) begin
                opa_q[i] <= '0;
                opb_q[i] <= '0;
                s_q[i]   <= '0;
            end
        end else if (enable) begin
            state_q <= state_d;
            beat_q  <= beat_d;
            out_q   <= last_beat;
            early_q <= early_d;
            if (bus.inReady && state_q == RUN) begin
                dropped_q <= 1'b1;
            end
            if (accept) begin
                sub_q <= bus.sub;
                for (int i = 0; i < VEC_LEN; i++) begin
                    opa_q[i] <= bus.A[i*IN_WIDTH +: IN_WIDTH];
                    opb_q[i] <= bus.B[i*IN_WIDTH +: IN_WIDTH];
                end
            end
            if (state_q == RUN) begin
                for (int i = 0; i < VEC_LEN; i++) begin
                    if (beat_q == BW'(i / LANES)) begin
                        s_q[i] <= lane_res[i % LANES];
                    end
                end
`ifdef VADD_SAT_EN
                for (int l = 0; l < LANES; l++) begin
                    if (lane_clamp[l]) begin
                        ovf_q <= 1'b1;
                    end
                end
`endif
            end
        end
    end

    always_comb begin
        bus.S = '0;
        for (int i = 0; i < VEC_LEN; i++) begin
            bus.S[i*EW +: EW] = s_q[i];
        end
    end

    assign bus.outReady      = out_q;
    assign bus.earlyOutReady = early_q;
    assign bus.busy          = (state_q == RUN);
    assign bus.dropped       = dropped_q;
`ifdef VADD_SAT_EN
    assign bus.ovf           = ovf_q;
`else
    assign bus.ovf           = 1'b0;
`endif
endmodule
